// File: rtl/tag_check.sv
// tag_check: tag compare, refill request and victim tag write.
// Ports:
//   clk, arst_n                     clock, asynchronous active-low reset
//   i_halt                          freeze all state
//   i_tag, i_set, i_data, i_valid   lookup from the tag array
//   o_ready                         lookup accepted this cycle
//   o_valid, o_hit, o_way, o_set    result to the data-array stage
//   o_refill_*                      refill request to memory
//   i_refill_ready, i_refill_done   memory handshake
//   o_w_*                           tag-array write port
// Macro TAG_CHECK_INVALID_FIRST_EN: victim is the lowest invalid way,
// falling back to the round-robin pointer.
module tag_check #(
    parameter int TAG_WIDTH  = 7,
    parameter int NUM_BLOCKS = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int ROW_WIDTH  = NUM_BLOCKS * (TAG_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [ADDR_WIDTH-1:0] i_set,
    input  logic [ROW_WIDTH-1:0]  i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic                  o_hit,
    output logic [NUM_BLOCKS-1:0] o_way,
    output logic [ADDR_WIDTH-1:0] o_set,
    output logic                  o_refill_valid,
    output logic [TAG_WIDTH-1:0]  o_refill_tag,
    output logic [ADDR_WIDTH-1:0] o_refill_set,
    input  logic                  i_refill_ready,
    input  logic                  i_refill_done,
    output logic                  o_w_valid,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ROW_WIDTH-1:0]  o_w_data,
    output logic [NUM_BLOCKS-1:0] o_w_wmask
);

    localparam int FW    = TAG_WIDTH + 1;
    localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_BLOCKS-1:0] victim_q, victim_d;
    logic                  use_ptr_q, use_ptr_d;
    logic                  valid_q, valid_d;
    logic                  hit_q, hit_d;
    logic [NUM_BLOCKS-1:0] way_q, way_d;
    logic [ADDR_WIDTH-1:0] set_q, set_d;
    logic                  rf_valid_q, rf_valid_d;
    logic [TAG_WIDTH-1:0]  rf_tag_q, rf_tag_d;
    logic [ADDR_WIDTH-1:0] rf_set_q, rf_set_d;
    logic                  w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ROW_WIDTH-1:0]  w_data_q, w_data_d;
    logic [NUM_BLOCKS-1:0] w_wmask_q, w_wmask_d;

    logic [NUM_BLOCKS-1:0] match_way;
    logic                  any_hit;
    logic [NUM_BLOCKS-1:0] ptr_oh;
    logic [PTR_W-1:0]      ptr_next;
    logic [NUM_BLOCKS-1:0] miss_victim;
    logic                  miss_use_ptr;

    assign o_ready = (state_q == IDLE) && !i_halt;

    // Lowest matching way wins if several (illegally) match.
    always_comb begin
        match_way = '0;
        any_hit   = 1'b0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (!any_hit && i_data[k*FW+TAG_WIDTH] &&
                i_data[k*FW +: TAG_WIDTH] == i_tag) begin
                match_way[k] = 1'b1;
                any_hit      = 1'b1;
            end
        end
    end

    assign ptr_oh   = NUM_BLOCKS'(1) << ptr_q;
    assign ptr_next = (ptr_q == PTR_W'(NUM_BLOCKS - 1)) ? '0
                                                       : ptr_q + 1'b1;

`ifdef TAG_CHECK_INVALID_FIRST_EN
    logic [NUM_BLOCKS-1:0] inv_way;
    logic                  any_inv;

    always_comb begin
        inv_way = '0;
        any_inv = 1'b0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (!any_inv && !i_data[k*FW+TAG_WIDTH]) begin
                inv_way[k] = 1'b1;
                any_inv    = 1'b1;
            end
        end
        miss_victim  = any_inv ? inv_way : ptr_oh;
        miss_use_ptr = !any_inv;
    end
`else
    assign miss_victim  = ptr_oh;
    assign miss_use_ptr = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        victim_d   = victim_q;
        use_ptr_d  = use_ptr_q;
        valid_d    = valid_q;
        hit_d      = hit_q;
        way_d      = way_q;
        set_d      = set_q;
        rf_valid_d = rf_valid_q;
        rf_tag_d   = rf_tag_q;
        rf_set_d   = rf_set_q;
        w_valid_d  = w_valid_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        w_wmask_d  = w_wmask_q;
        if (!i_halt) begin
            valid_d   = 1'b0;
            w_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        valid_d = 1'b1;
                        set_d   = i_set;
                        hit_d   = any_hit;
                        way_d   = match_way;
                        if (!any_hit) begin
                            rf_valid_d = 1'b1;
                            rf_tag_d   = i_tag;
                            rf_set_d   = i_set;
                            victim_d   = miss_victim;
                            use_ptr_d  = miss_use_ptr;
                            state_d    = REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_refill_ready) begin
                        rf_valid_d = 1'b0;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (i_refill_done) begin
                        w_valid_d = 1'b1;
                        w_addr_d  = rf_set_q;
                        w_wmask_d = victim_q;
                        w_data_d  = {NUM_BLOCKS{{1'b1, rf_tag_q}}};
                        valid_d   = 1'b1;
                        hit_d     = 1'b1;
                        way_d     = victim_q;
                        set_d     = rf_set_q;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    if (use_ptr_q) ptr_d = ptr_next;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            victim_q   <= '0;
            use_ptr_q  <= 1'b0;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            set_q      <= '0;
            rf_valid_q <= 1'b0;
            rf_tag_q   <= '0;
            rf_set_q   <= '0;
            w_valid_q  <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            w_wmask_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            victim_q   <= victim_d;
            use_ptr_q  <= use_ptr_d;
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            set_q      <= set_d;
            rf_valid_q <= rf_valid_d;
            rf_tag_q   <= rf_tag_d;
            rf_set_q   <= rf_set_d;
            w_valid_q  <= w_valid_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            w_wmask_q  <= w_wmask_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_hit          = hit_q;
    assign o_way          = way_q;
    assign o_set          = set_q;
    assign o_refill_valid = rf_valid_q;
    assign o_refill_tag   = rf_tag_q;
    assign o_refill_set   = rf_set_q;
    assign o_w_valid      = w_valid_q;
    assign o_w_addr       = w_addr_q;
    assign o_w_data       = w_data_q;
    assign o_w_wmask      = w_wmask_q;

endmodule

// File: tb/tb_tag_check.sv
// tb_tag_check: directed vector bench for tag_check.
// Table of lookups plus hand sequences for refill, halt and reset.
module tb_tag_check;

    localparam int TW = 7;
    localparam int NB = 4;
    localparam int AW = 4;
    localparam int RW = NB * (TW + 1);

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic          i_halt = 1'b0;
    logic [TW-1:0] i_tag = '0;
    logic [AW-1:0] i_set = '0;
    logic [RW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_refill_ready = 1'b0;
    logic          i_refill_done = 1'b0;
    logic          o_ready;
    logic          o_valid;
    logic          o_hit;
    logic [NB-1:0] o_way;
    logic [AW-1:0] o_set;
    logic          o_refill_valid;
    logic [TW-1:0] o_refill_tag;
    logic [AW-1:0] o_refill_set;
    logic          o_w_valid;
    logic [AW-1:0] o_w_addr;
    logic [RW-1:0] o_w_data;
    logic [NB-1:0] o_w_wmask;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tag_check #(
        .TAG_WIDTH(TW), .NUM_BLOCKS(NB), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
        .i_tag(i_tag), .i_set(i_set), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready),
        .o_valid(o_valid), .o_hit(o_hit), .o_way(o_way),
        .o_set(o_set), .o_refill_valid(o_refill_valid),
        .o_refill_tag(o_refill_tag), .o_refill_set(o_refill_set),
        .i_refill_ready(i_refill_ready),
        .i_refill_done(i_refill_done), .o_w_valid(o_w_valid),
        .o_w_addr(o_w_addr), .o_w_data(o_w_data),
        .o_w_wmask(o_w_wmask)
    );

    typedef struct {
        logic [RW-1:0] row;
        logic [TW-1:0] tag;
        logic [AW-1:0] set;
        logic          hit;
        logic [NB-1:0] way;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [RW-1:0] mk(input logic [3:0] v,
        input logic [6:0] t0, input logic [6:0] t1,
        input logic [6:0] t2, input logic [6:0] t3);
        return {v[3], t3, v[2], t2, v[1], t1, v[0], t0};
    endfunction

    function automatic logic [RW-1:0] fill_row(input logic [6:0] t);
        logic [RW-1:0] r;
        for (int k = 0; k < NB; k++) r[k*8 +: 8] = {1'b1, t};
        return r;
    endfunction

    function automatic logic [62:0] all_outs();
        return {o_valid, o_hit, o_way, o_set, o_refill_valid,
                o_refill_tag, o_refill_set, o_w_valid, o_w_addr,
                o_w_data, o_w_wmask};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input string nm);
        arst_n = 1'b0;
        #1;
        chk({nm, ".outs"}, 64'(all_outs()), 64'd0);
        chk({nm, ".ready"}, 64'(o_ready), 64'd1);
        step();
        arst_n = 1'b1;
    endtask

    // One lookup; on a miss, runs the refill with immediate handshakes.
    task automatic lookup(input vec_t v, input string nm);
        i_data  = v.row;
        i_tag   = v.tag;
        i_set   = v.set;
        i_valid = 1'b1;
        chk({nm, ".ready"}, 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        chk({nm, ".res"}, 64'({o_valid, o_hit, o_way, o_set}),
            64'({1'b1, v.hit, v.hit ? v.way : 4'b0, v.set}));
        if (!v.hit) begin
            chk({nm, ".req"},
                64'({o_refill_valid, o_refill_tag, o_refill_set}),
                64'({1'b1, v.tag, v.set}));
            i_refill_ready = 1'b1;
            step();
            i_refill_ready = 1'b0;
            chk({nm, ".wait"}, 64'({o_refill_valid, o_ready}), 64'd0);
            i_refill_done = 1'b1;
            step();
            i_refill_done = 1'b0;
            chk({nm, ".fill"},
                64'({o_w_valid, o_w_addr, o_w_wmask,
                     o_valid, o_hit, o_way}),
                64'({1'b1, v.set, v.way, 1'b1, 1'b1, v.way}));
            chk({nm, ".wdata"}, 64'(o_w_data), 64'(fill_row(v.tag)));
            step();
            chk({nm, ".idle"}, 64'({o_w_valid, o_valid, o_ready}),
                64'd1);
        end
    endtask

    initial begin
        vec_t          v;
        logic [RW-1:0] c_row;
        logic [RW-1:0] hit_row;

        vecs[0] = '{mk(4'b0100, 0, 0, 7'h15, 0), 7'h15, 4'd3,
                    1'b1, 4'b0100};
        vecs[1] = '{mk(4'b1010, 0, 7'h11, 0, 7'h11), 7'h11, 4'd7,
                    1'b1, 4'b0010};
        vecs[2] = '{mk(4'b1111, 5, 6, 7, 8), 7'h05, 4'hF,
                    1'b1, 4'b0001};
        vecs[3] = '{mk(4'b1111, 5, 6, 7, 8), 7'h08, 4'h0,
                    1'b1, 4'b1000};
        vecs[4] = '{mk(4'b1111, 1, 2, 3, 4), 7'h09, 4'h1,
                    1'b0, 4'b0010};
        vecs[5] = '{mk(4'b1111, 1, 2, 3, 4), 7'h0A, 4'h2,
                    1'b0, 4'b0100};
        vecs[6] = '{mk(4'b1111, 1, 2, 3, 4), 7'h11, 4'h4,
                    1'b0, 4'b1000};
        vecs[7] = '{mk(4'b1111, 1, 2, 3, 4), 7'h12, 4'h6,
                    1'b0, 4'b0001};
        vecs[8] = '{mk(4'b1111, 7'h20, 7'h21, 7'h22, 7'h23), 7'h22,
                    4'h9, 1'b1, 4'b0100};
`ifdef TAG_CHECK_INVALID_FIRST_EN
        c_row = mk(4'b1111, 1, 2, 3, 4);
`else
        c_row = '0;
`endif
        hit_row = mk(4'b0001, 7'h33, 0, 0, 0);

        #2;
        reset_dut("rst0");

        // Halt in IDLE blocks acceptance.
        i_halt = 1'b1;
        #1;
        chk("halt_idle.ready", 64'(o_ready), 64'd0);
        i_halt = 1'b0;

        // Miss with a stalled refill, ignored early done and halt.
        i_data  = c_row;
        i_tag   = 7'h2A;
        i_set   = 4'd5;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("miss.res", 64'({o_valid, o_hit, o_way, o_set}),
            64'({1'b1, 1'b0, 4'b0, 4'd5}));
        for (int c = 0; c < 3; c++) begin
            i_refill_done = (c == 1);
            chk($sformatf("req_hold%0d", c),
                64'({o_refill_valid, o_refill_tag, o_refill_set,
                     o_ready}),
                64'({1'b1, 7'h2A, 4'd5, 1'b0}));
            step();
        end
        i_refill_done = 1'b0;
        chk("req.valid_drop", 64'(o_valid), 64'd0);
        i_halt = 1'b1;
        i_refill_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("req_halt%0d", c),
                64'({o_refill_valid, o_refill_tag, o_refill_set,
                     o_ready}),
                64'({1'b1, 7'h2A, 4'd5, 1'b0}));
        end
        i_halt = 1'b0;
        step();
        i_refill_ready = 1'b0;
        chk("wait.req_drop", 64'(o_refill_valid), 64'd0);
        i_data  = hit_row;
        i_tag   = 7'h33;
        i_set   = 4'd1;
        i_valid = 1'b1;
        #1;
        chk("wait.ready", 64'(o_ready), 64'd0);
        step();
        i_valid = 1'b0;
        chk("wait.no_valid", 64'(o_valid), 64'd0);
        i_refill_done = 1'b1;
        step();
        i_refill_done = 1'b0;
        chk("fill", 64'({o_w_valid, o_w_addr, o_w_wmask,
                          o_valid, o_hit, o_way, o_set}),
            64'({1'b1, 4'd5, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'd5}));
        chk("fill.wdata", 64'(o_w_data), 64'(fill_row(7'h2A)));
        step();
        chk("post_fill", 64'({o_w_valid, o_valid, o_ready}), 64'd1);

        // Table: back-to-back hits and round-robin misses.
        for (int i = 0; i < 9; i++) begin
            lookup(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].hit)
                chk($sformatf("vec%0d.ready_after", i),
                    64'(o_ready), 64'd1);
        end

        // Reset while waiting for the refill.
        i_data  = mk(4'b1111, 1, 2, 3, 4);
        i_tag   = 7'h50;
        i_set   = 4'd8;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_refill_ready = 1'b1;
        step();
        i_refill_ready = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("rst_wait.outs", 64'(all_outs()), 64'd0);
        chk("rst_wait.ready", 64'(o_ready), 64'd1);
        i_refill_done = 1'b1;
        step();
        step();
        i_refill_done = 1'b0;
        arst_n = 1'b1;
        chk("rst_wait.no_fill", 64'({o_w_valid, o_valid}), 64'd0);
        v = '{mk(4'b1111, 1, 2, 3, 4), 7'h51, 4'd9, 1'b0, 4'b0001};
        lookup(v, "after_rst");

        // Victim choice with invalid ways present.
        reset_dut("rst1");
`ifdef TAG_CHECK_INVALID_FIRST_EN
        v = '{mk(4'b1101, 1, 2, 3, 4), 7'h60, 4'hA, 1'b0, 4'b0010};
        lookup(v, "inv1");
        v = '{mk(4'b1111, 1, 2, 3, 4), 7'h61, 4'hB, 1'b0, 4'b0001};
        lookup(v, "inv_ptr");
        v = '{mk(4'b0111, 1, 2, 3, 7'h40), 7'h40, 4'hC, 1'b0,
              4'b1000};
        lookup(v, "inv_match");
`else
        v = '{mk(4'b1101, 1, 2, 3, 4), 7'h60, 4'hA, 1'b0, 4'b0001};
        lookup(v, "inv1");
        v = '{mk(4'b1111, 1, 2, 3, 4), 7'h61, 4'hB, 1'b0, 4'b0010};
        lookup(v, "inv_ptr");
        v = '{mk(4'b0111, 1, 2, 3, 7'h40), 7'h40, 4'hC, 1'b0,
              4'b0100};
        lookup(v, "inv_match");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
